// File: rtl/morse_tx.sv
// Morse letter keyer: sends up to four dot/dash symbols from a latched pattern,
// with unit-length intra-letter spaces and a three-unit letter gap.
module morse_tx #(
  parameter int UNIT_CYCLES = 12000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] code,
  input  logic [2:0] len,
  output logic       led,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, LGAP} state_t;

  localparam logic [31:0] UNIT_M1 = 32'(longint'(UNIT_CYCLES) - 1);
  localparam logic [31:0] TRIPLE_M1 = 32'(3 * longint'(UNIT_CYCLES) - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  code_q, code_d;
  logic [2:0]  rem_q, rem_d;
  logic        led_q, led_d;

  function automatic logic [31:0] mark_load(input logic dash);
    return dash ? TRIPLE_M1 : UNIT_M1;
  endfunction

  function automatic logic [2:0] clamp_len(input logic [2:0] l);
    return (l > 3'd4) ? 3'd4 : l;
  endfunction

  // Counter loads (duration - 1) on state entry and counts down to 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == 32'd0) ? 32'd0 : cnt_q - 32'd1;
    code_d  = code_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (start && (len != 3'd0)) begin
          state_d = MARK;
          code_d  = code;
          rem_d   = clamp_len(len);
          cnt_d   = mark_load(code[3]);
        end
      end
      MARK: begin
        if (cnt_q == 32'd0) begin
          if (rem_q == 3'd1) begin
            state_d = LGAP;
            cnt_d   = TRIPLE_M1;
            rem_d   = 3'd0;
          end else begin
            state_d = SPACE;
            cnt_d   = UNIT_M1;
            rem_d   = rem_q - 3'd1;
            code_d  = {code_q[2:0], 1'b0};
          end
        end
      end
      SPACE: begin
        if (cnt_q == 32'd0) begin
          state_d = MARK;
          cnt_d   = mark_load(code_q[3]);
        end
      end
      LGAP: begin
        if (cnt_q == 32'd0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    led_d = (state_d == MARK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      code_q  <= 4'd0;
      rem_q   <= 3'd0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      rem_q   <= rem_d;
      led_q   <= led_d;
    end
  end

  assign led  = led_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == LGAP) && (cnt_q == 32'd0);

endmodule

// File: tb/tb_morse_tx.sv
// Bench for morse_tx: a waveform-queue model built from the Morse timing rules,
// checked every cycle, plus literal busy lengths and led run lengths.
module tb_morse_tx;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] code = 4'd0;
  logic [2:0] len = 3'd0;
  logic       led, busy, done;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;
  bit exp_q[$];
  int runs[$];

  morse_tx #(.UNIT_CYCLES(U)) dut (
    .clk(clk), .rst(rst), .start(start), .code(code), .len(len),
    .led(led), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Model: on acceptance, expand the whole letter into a per-cycle led sequence.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end else if (start && len != 3'd0) begin
      int n;
      n = (len > 3'd4) ? 4 : int'(len);
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < (code[3-i] ? 3 * U : U); k++) exp_q.push_back(1'b1);
        if (i < n - 1) for (int k = 0; k < U; k++) exp_q.push_back(1'b0);
      end
      for (int k = 0; k < 3 * U; k++) exp_q.push_back(1'b0);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("led", int'(led), (exp_q.size() > 0) ? int'(exp_q[0]) : 0);
      check("busy", int'(busy), int'(exp_q.size() > 0));
      check("done", int'(done), int'(exp_q.size() == 1));
    end
  end

  // Pulses start, then follows the letter; optionally injects a second start
  // with a new pattern, or a reset, at busy cycle number inj/abort_at.
  task automatic send(input logic [3:0] c, input logic [2:0] l, input int exp_busy,
                      input int exp_done, input int inj, input int abort_at,
                      input string name);
    int n, dn, run;
    logic prev;
    code  = c;
    len   = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; dn = 0; run = 0; prev = 1'b1;
    runs.delete();
    while (busy && n < 500) begin
      n++;
      if (done) dn++;
      if (led == prev) run++;
      else begin runs.push_back(run); run = 1; prev = led; end
      if (n == inj) begin start = 1'b1; code = 4'b0101; len = 3'd2; end
      else start = 1'b0;
      if (n == abort_at) rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    start = 1'b0;
    runs.push_back(run);
    check({name, "_busy_cycles"}, n, exp_busy);
    check({name, "_done_pulses"}, dn, exp_done);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_led", int'(led), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    // "C": dash dot dash dot
    send(4'b1010, 3'd4, 56, 1, -1, -1, "C");
    check("C_run_count", runs.size(), 8);
    if (runs.size() == 8) begin
      int want[8] = '{12, 4, 4, 4, 12, 4, 4, 12};
      for (int i = 0; i < 8; i++) check($sformatf("C_run%0d", i), runs[i], want[i]);
    end

    // "E" starting in the cycle right after the previous idle return
    send(4'b0000, 3'd1, 16, 1, -1, -1, "E");

    // len=0 ignored
    code = 4'b1111; len = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("len0_busy", int'(busy), 0);
    check("len0_led", int'(led), 0);
    repeat (3) @(negedge clk);
    check("len0_busy_later", int'(busy), 0);

    // len=7 clamps to four dashes
    send(4'b1111, 3'd7, 72, 1, -1, -1, "len7");

    // second start with a new pattern 10 cycles in is ignored
    send(4'b1010, 3'd4, 56, 1, 10, -1, "C_ignore");
    check("C_ignore_runs", runs.size(), 8);

    // back-to-back: start in the cycle after done, led must rise after one edge
    code = 4'b0000; len = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_led", int'(led), 1);
    check("b2b_busy", int'(busy), 1);
    repeat (15) @(negedge clk);
    check("b2b_done", int'(done), 1);
    @(negedge clk);

    // reset in cycle 20 of "C" aborts with no done
    send(4'b1010, 3'd4, 20, 0, -1, 20, "C_abort");
    check("abort_led", int'(led), 0);
    send(4'b0000, 3'd1, 16, 1, -1, -1, "E_after_abort");

    // reset and start together
    rst = 1'b1; start = 1'b1; code = 4'b1010; len = 3'd4;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", int'(busy), 0);
    @(negedge clk);
    check("rst_start_busy2", int'(busy), 0);
    check("rst_start_led", int'(led), 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/morse_tx.md
MORSE_TX -- requirements
Module: morse_tx

Interface
REQ-001 SHALL have parameter: UNIT_CYCLES, 12000000, clk cycles per Morse time unit (legal >= 1).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: start  input  1  one-cycle request to transmit the presented letter.
REQ-005 SHALL have port: code  input  4  symbol pattern; bit=1 dash (traco), bit=0 dot (ponto); code[3] sent first.
REQ-006 SHALL have port: len  input  3  number of symbols to send, taken from code[3] downward.
REQ-007 SHALL have port: led  output  1  keyed output; 1 = mark (light on), 0 = space.
REQ-008 SHALL have port: busy  output  1  high while a letter is in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse at end of letter.

Function
REQ-010 SHALL implement FSM states IDLE, MARK, SPACE, LGAP (letter gap).
REQ-011 SHALL accept start only in IDLE; start while busy=1 SHALL be ignored, with no effect on the letter in progress.
REQ-012 On an accepted start at edge N, SHALL latch code and len; SHALL present busy=1 and led=1 (MARK, first symbol) after edge N.
REQ-013 len=0 with start SHALL be ignored (stay IDLE, busy=0, no done); len>4 SHALL be treated as 4.
REQ-014 MARK duration SHALL be 1*UNIT_CYCLES cycles for a dot and 3*UNIT_CYCLES for a dash, with led=1 throughout.
REQ-015 After a MARK that is not the last symbol, SHALL enter SPACE for exactly 1*UNIT_CYCLES cycles with led=0, then MARK of the next lower code bit.
REQ-016 After the last MARK, SHALL enter LGAP for exactly 3*UNIT_CYCLES cycles with led=0; no SPACE precedes LGAP.
REQ-017 On the last LGAP cycle, SHALL assert done=1 for exactly one cycle; busy SHALL fall and state SHALL return to IDLE on the same edge that ends done (done and busy=1 coincide for one cycle, then both 0).
REQ-018 Total busy cycles per letter SHALL equal UNIT_CYCLES*(sum of mark units + (len-1) + 3).
REQ-019 A start asserted in the cycle after done SHALL be accepted (back-to-back letters, no dead cycle beyond IDLE).
REQ-020 Duration counter SHALL be at least 32 bits wide, load on every state entry, and never wrap within a state for any legal UNIT_CYCLES.
REQ-021 Changes on code/len while busy SHALL NOT affect output (latched copy used).
REQ-022 led SHALL be a registered output, glitch-free; led=0 in IDLE, SPACE, LGAP.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE, led=0, busy=0, done=0, counter=0, latched code/len=0.
REQ-024 rst SHALL take priority over start in the same cycle; start is dropped.
REQ-025 rst asserted mid-letter (any state) SHALL abort the letter with no done pulse; led=0 on the following cycle.
REQ-026 After rst deasserts, first start SHALL be accepted on the next edge.

Verification (UNIT_CYCLES=4)
REQ-027 code=1010, len=4 ("C"), start 1 cycle -> led high 12, low 4, high 4, low 4, high 12, low 4, high 4, low 12; done pulse on final cycle; busy=56 cycles.
REQ-028 code=0000, len=1 ("E") -> led high 4, low 12; busy=16 cycles; one done pulse.
REQ-029 start with len=0 -> busy stays 0, led 0, no done; start with len=7, code=1111 -> four dashes, busy=12*4+3*4+12=72 cycles.
REQ-030 second start and code change 10 cycles into a letter -> waveform identical to REQ-027; start in the cycle after done -> next letter's led=1 begins one edge later.
REQ-031 rst asserted in cycle 20 of REQ-027 letter -> led=0, busy=0 next cycle, no done; subsequent start of "E" matches REQ-028.
REQ-032 rst and start same cycle -> remains IDLE, busy=0.
